// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the phy_tx clock scheduler.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int DEF_DIV_2F   = 4;
    localparam int DEF_DIV_F    = 2;
    localparam int DEF_WARMUP_F = 2;

    // Counter width for a modulo-m counter; never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/phy_tx_div_cnt.sv
// Modulo-MOD counter with synchronous clear and terminal-count decode.
module phy_tx_div_cnt #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk_8f,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == W'(MOD - 1));

    // Next count: clear dominates, otherwise step and wrap at MOD-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = tc ? '0 : cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk_8f) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/phy_tx_clk_sched.sv
// Clock-enable sequencer for phy_tx: start/stop handshake, warm-up, and
// clk_f-aligned graceful stop. Optional square-wave clock outputs are
// built when CLK_OUT_EN is defined.
module phy_tx_clk_sched
    import phy_tx_pkg::*;
#(
    parameter int DIV_2F   = DEF_DIV_2F,
    parameter int DIV_F    = DEF_DIV_F,
    parameter int WARMUP_F = DEF_WARMUP_F
) (
    input  logic                      clk_8f,
    input  logic                      reset,
    input  logic                      start_req,
    input  logic                      stop_req,
`ifdef CLK_OUT_EN
    output logic                      clk_2f,
    output logic                      clk_f,
`endif
    output logic                      busy,
    output logic                      ready,
    output logic                      ce_2f,
    output logic                      ce_f,
    output logic [$clog2(DIV_2F)-1:0] phase
);

    localparam int W8 = cnt_w(DIV_2F);
    localparam int W2 = cnt_w(DIV_F);
    localparam int WW = cnt_w(WARMUP_F);

    state_e         state_q, state_d;
    logic           active, clr;
    logic [W8-1:0]  cnt8;
    logic [W2-1:0]  cnt2;
    logic [WW-1:0]  warm;
    logic           cnt8_tc, cnt2_tc, warm_tc;

    // Counters are held at zero in IDLE and cleared on any return to IDLE,
    // so a restart always begins a fresh period.
    assign active = (state_q != ST_IDLE);
    assign clr    = (state_q == ST_IDLE) || (state_d == ST_IDLE);

    phy_tx_div_cnt #(.MOD(DIV_2F), .W(W8)) u_cnt8 (
        .clk_8f(clk_8f), .reset(reset), .clr(clr), .inc(1'b1),
        .cnt(cnt8), .tc(cnt8_tc)
    );

    phy_tx_div_cnt #(.MOD(DIV_F), .W(W2)) u_cnt2 (
        .clk_8f(clk_8f), .reset(reset), .clr(clr), .inc(ce_2f),
        .cnt(cnt2), .tc(cnt2_tc)
    );

    phy_tx_div_cnt #(.MOD(WARMUP_F), .W(WW)) u_warm (
        .clk_8f(clk_8f), .reset(reset), .clr(clr), .inc(ce_f),
        .cnt(warm), .tc(warm_tc)
    );

    // Strobes decode registered state only.
    assign ce_2f = active && cnt8_tc;
    assign ce_f  = ce_2f && cnt2_tc;
    assign busy  = active;
    assign ready = (state_q == ST_RUN);
    assign phase = active ? cnt8[$clog2(DIV_2F)-1:0] : '0;

    // State register.
    always_ff @(posedge clk_8f) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: start wins in IDLE, stop wins elsewhere; RUN stop on a
    // ce_f boundary skips DRAIN since the period is already complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_req) state_d = ST_WARMUP;
            ST_WARMUP: begin
                if (stop_req)              state_d = ST_IDLE;
                else if (ce_f && warm_tc)  state_d = ST_RUN;
            end
            ST_RUN:    if (stop_req) state_d = ce_f ? ST_IDLE : ST_DRAIN;
            ST_DRAIN:  if (ce_f)     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef CLK_OUT_EN
    logic clk_2f_q, clk_2f_d, clk_f_q, clk_f_d;
    logic tgl_2f, tgl_f;

    assign tgl_2f = active && (cnt8_tc || (cnt8 == W8'(DIV_2F / 2 - 1)));
    assign tgl_f  = (DIV_F % 2 == 1) ? ce_f
                  : (ce_2f && (cnt2_tc || (cnt2 == W2'(DIV_F / 2 - 1))));
    assign clk_2f = clk_2f_q;
    assign clk_f  = clk_f_q;

    // Square waves toggle on period boundaries and are forced low in IDLE.
    always_comb begin
        clk_2f_d = clk_2f_q ^ tgl_2f;
        clk_f_d  = clk_f_q ^ tgl_f;
        if (state_d == ST_IDLE) begin
            clk_2f_d = 1'b0;
            clk_f_d  = 1'b0;
        end
    end

    // Square-wave registers.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            clk_2f_q <= 1'b0;
            clk_f_q  <= 1'b0;
        end else begin
            clk_2f_q <= clk_2f_d;
            clk_f_q  <= clk_f_d;
        end
    end
`endif

endmodule
